// File: rtl/adder_accumulator_nbit.sv
// Packet accumulator: sums a valid/ready stream of N-bit operands and
// presents total, sticky carry flag and saturating beat count.
//
// full_adder_nbit ports:
//   a, b [N-1:0] operands   cin carry-in
//   sum  [N-1:0] a+b+cin    cout carry-out
//
// adder_accumulator_nbit ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in_data[N]/in_last     operand stream
//   out_valid/out_ready                      result handshake
//   out_sum[N]/out_ovf/out_count[CNT_W]      packet result

module full_adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

module adder_accumulator_nbit #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [N-1:0]     acc;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             rdy_q;
  logic             vld_q;

  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             in_xfer;
  logic             out_xfer;

  full_adder_nbit #(.N(N)) u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_xfer  = in_valid && rdy_q;
  assign out_xfer = vld_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_xfer) begin
            // first beat loads the operand directly
            acc   <= in_data;
            ovf   <= 1'b0;
            count <= CNT_ONE;
            if (in_last) begin
              state <= HOLD;
              rdy_q <= 1'b0;
              vld_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc   <= add_sum;
            ovf   <= ovf | add_cout;
            count <= (count == CNT_MAX) ? count : count + CNT_ONE;
            if (in_last) begin
              state <= HOLD;
              rdy_q <= 1'b0;
              vld_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // no bypass: in_ready rises only the cycle after the handshake
          if (out_xfer) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = count;

endmodule

// File: tb/tb_adder_accumulator_nbit.sv
// Bench for adder_accumulator_nbit: directed packets plus random packets
// checked through a result queue filled as beats are accepted.

module tb_adder_accumulator_nbit;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  typedef struct packed {
    logic [N-1:0]     sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } res_t;

  res_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  logic [N-1:0]     m_acc;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;
  bit               m_first;

  adder_accumulator_nbit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // result monitor: a handshake completes at the next posedge
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      res_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_sum), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        n_popped++;
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        chk("out_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  task automatic model_reset();
    m_first = 1'b1;
    m_acc   = '0;
    m_ovf   = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic model_beat(input logic [N-1:0] d, input logic last);
    logic [N:0] full;
    res_t r;
    if (m_first) begin
      m_acc = d;
      m_ovf = 1'b0;
      m_cnt = 1;
      m_first = 1'b0;
    end else begin
      full  = {1'b0, m_acc} + {1'b0, d};
      m_acc = full[N-1:0];
      m_ovf = m_ovf | full[N];
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    if (last) begin
      r.sum = m_acc;
      r.ovf = m_ovf;
      r.cnt = m_cnt;
      exp_q.push_back(r);
      n_pushed++;
      m_first = 1'b1;
    end
  endtask

  // drives from posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [N-1:0] d, input logic last);
    int tries;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tries = 0;
    ok = 1'b0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
      end else begin
        tries++;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    if (!ok) chk("in_ready_timeout", 32'(tries), 32'd0);
    @(posedge clk);
    #1;
    if (ok) model_beat(d, last);
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_last   = 1'b1;
    out_ready = 1'b1;
    model_reset();

    // reset dominates in_valid
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    tick();

    // basic packet and latency
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_sum", 32'(out_sum), 32'h60);
    chk("lat_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    tick();

    // overflow is sticky
    send(8'hF0, 1'b0);
    send(8'h20, 1'b0);
    send(8'h01, 1'b1);
    tick();
    tick();

    // backpressure
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", 32'(out_sum), 32'h66);
      chk("bp_out_count", 32'(out_count), 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd0);
    tick();
    send(8'hAA, 1'b1);
    tick();
    tick();

    // counter saturation
    for (int i = 0; i < 20; i++) send(8'h01, i == 19);
    tick();
    tick();

    // reset mid-packet discards partial result
    send(8'h40, 1'b0);
    send(8'h50, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    send(8'h05, 1'b1);
    tick();
    tick();
    chk("rst_mid_results", 32'(n_popped), 32'(n_pushed));

    // random packets with random backpressure
    for (int p = 0; p < 100; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        send(N'($urandom), b == len - 1);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("result_count", 32'(n_popped), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
